// File: rtl/dma_packet_receiver_pkg.sv
// dma_pkt_pkg: constants and types shared by both directions of the DMA UART link.
//   - Host-to-device and device-to-host packet type codes (header byte values).
//   - TILE_BYTES / TILE_BITS: size of one read-response tile.
//   - Receiver state and packet-kind enums, plus a header decode helper.
package dma_pkt_pkg;

  // Host-to-device header bytes
  localparam logic [7:0] PKT_H2D_READ_RESP  = 8'd1;
  localparam logic [7:0] PKT_H2D_PROG_START = 8'd2;

  // Device-to-host header bytes
  localparam logic [7:0] PKT_D2H_READ_REQ   = 8'd2;
  localparam logic [7:0] PKT_D2H_WRITE      = 8'd3;
  localparam logic [7:0] PKT_D2H_END_PROG   = 8'd4;

  // 18 x 16-bit elements per read response
  localparam int unsigned TILE_BYTES = 36;
  localparam int unsigned TILE_BITS  = TILE_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX_ADDR,
    ST_RX_DATA,
    ST_COMMIT
  } rx_state_e;

  typedef enum logic {
    PK_RESP,
    PK_PROG
  } pkt_kind_e;

  typedef struct packed {
    logic      valid;
    pkt_kind_e kind;
  } hdr_dec_t;

  function automatic hdr_dec_t decode_h2d_header(input logic [7:0] b);
    hdr_dec_t d;
    d.valid = 1'b0;
    d.kind  = PK_RESP;
    if (b == PKT_H2D_READ_RESP) begin
      d.valid = 1'b1;
      d.kind  = PK_RESP;
    end else if (b == PKT_H2D_PROG_START) begin
      d.valid = 1'b1;
      d.kind  = PK_PROG;
    end
    return d;
  endfunction

endpackage

// File: rtl/dma_packet_receiver_if.sv
// dma_packet_receiver_if: byte stream in from the UART receiver, queue pushes out,
// and error pulses.
//   slave  modport: receiver side (consumes bytes, drives queues/errors)
//   master modport: environment side (UART + queues)
//   rx_valid/rx_data                 byte strobe and value
//   dma_recv_read_queue_*            read-response queue (data=addr, data2=tile)
//   prog_start_queue_*               program-start queue
//   err_bad_type/err_timeout/err_overflow  one-cycle error pulses
interface dma_packet_receiver_if;
  import dma_pkt_pkg::*;

  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic [15:0]          dma_recv_read_queue_data;
  logic [TILE_BITS-1:0] dma_recv_read_queue_data2;
  logic                 dma_recv_read_queue_full;
  logic                 dma_recv_read_queue_we;
  logic [15:0]          prog_start_queue_data;
  logic                 prog_start_queue_full;
  logic                 prog_start_queue_we;
  logic                 err_bad_type;
  logic                 err_timeout;
  logic                 err_overflow;

  modport slave (
    input  rx_valid, rx_data, dma_recv_read_queue_full, prog_start_queue_full,
    output dma_recv_read_queue_data, dma_recv_read_queue_data2, dma_recv_read_queue_we,
           prog_start_queue_data, prog_start_queue_we,
           err_bad_type, err_timeout, err_overflow
  );

  modport master (
    output rx_valid, rx_data, dma_recv_read_queue_full, prog_start_queue_full,
    input  dma_recv_read_queue_data, dma_recv_read_queue_data2, dma_recv_read_queue_we,
           prog_start_queue_data, prog_start_queue_we,
           err_bad_type, err_timeout, err_overflow
  );
endinterface

// File: rtl/dma_packet_receiver_timeout.sv
// rx_timeout_counter: counts idle cycles while enabled; o_expire is high while
// enabled and the count sits at CYCLES-1. The owner decides whether a same-cycle
// byte overrides the expiry.
//   clk, reset  clock, synchronous active-high reset
//   i_clear     zero the count (takes priority over counting)
//   i_enable    count this cycle
//   o_expire    idle limit reached
module rx_timeout_counter #(
  parameter int unsigned CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  localparam int unsigned   W    = $clog2(CYCLES + 1);
  localparam logic [W-1:0]  LAST = W'(CYCLES - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_enable && (r_cnt == LAST);
endmodule

// File: rtl/dma_packet_receiver.sv
// dma_packet_receiver: host-to-device half of the DMA UART link. Parses framed
// packets (header, big-endian address, optional tile) and pushes them into the
// read-response or program-start queue. Malformed, stalled or unqueueable packets
// are dropped with a one-cycle error pulse.
//   clk, reset  clock, synchronous active-high reset
//   bus         dma_packet_receiver_if.slave (byte input, queue pushes, errors)
// All queue/error outputs are registered: a push appears two cycles after the
// final byte's strobe cycle.
module dma_packet_receiver
  import dma_pkt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  dma_packet_receiver_if.slave  bus
);
  localparam logic [15:0] DATA_LAST = 16'(TILE_BYTES - 1);

  rx_state_e            r_state;
  pkt_kind_e            r_kind;
  logic [15:0]          r_cnt;
  logic [15:0]          r_addr;
  logic [TILE_BITS-1:0] r_tile;

  logic [15:0]          r_rd_data;
  logic [TILE_BITS-1:0] r_rd_data2;
  logic                 r_rd_we;
  logic [15:0]          r_ps_data;
  logic                 r_ps_we;
  logic                 r_err_bad_type;
  logic                 r_err_timeout;
  logic                 r_err_overflow;
  logic                 r_bad_pend;

  rx_state_e w_state_nxt;
  pkt_kind_e w_kind_nxt;
  hdr_dec_t  w_hdr;
  logic      w_addr_hi_ld;
  logic      w_addr_lo_ld;
  logic      w_tile_shift;
  logic      w_cnt_inc;
  logic      w_rd_push;
  logic      w_ps_push;
  logic      w_ovf;
  logic      w_bad;
  logic      w_tmo;
  logic      w_to_enable;
  logic      w_to_clear;
  logic      w_expire;

  assign w_to_enable = (r_state == ST_RX_ADDR) || (r_state == ST_RX_DATA);
  assign w_to_clear  = bus.rx_valid || !w_to_enable;

  rx_timeout_counter #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_to_clear),
    .i_enable (w_to_enable),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_kind_nxt   = r_kind;
    w_hdr        = decode_h2d_header(bus.rx_data);
    w_addr_hi_ld = 1'b0;
    w_addr_lo_ld = 1'b0;
    w_tile_shift = 1'b0;
    w_cnt_inc    = 1'b0;
    w_rd_push    = 1'b0;
    w_ps_push    = 1'b0;
    w_ovf        = 1'b0;
    w_bad        = 1'b0;
    w_tmo        = 1'b0;

    unique case (r_state)
      // COMMIT finishes the previous packet and decodes a header like IDLE,
      // so a header byte arriving on the commit cycle is not lost.
      ST_IDLE, ST_COMMIT: begin
        if (r_state == ST_COMMIT) begin
          w_state_nxt = ST_IDLE;
          if (r_kind == PK_RESP) begin
            if (!bus.dma_recv_read_queue_full) w_rd_push = 1'b1;
            else                               w_ovf     = 1'b1;
          end else begin
            if (!bus.prog_start_queue_full)    w_ps_push = 1'b1;
            else                               w_ovf     = 1'b1;
          end
        end
        if (bus.rx_valid) begin
          if (w_hdr.valid) begin
            w_state_nxt = ST_RX_ADDR;
            w_kind_nxt  = w_hdr.kind;
          end else begin
            w_bad = 1'b1;
          end
        end
      end

      ST_RX_ADDR: begin
        if (bus.rx_valid) begin
          if (r_cnt == 16'd0) begin
            w_addr_hi_ld = 1'b1;
            w_cnt_inc    = 1'b1;
          end else begin
            w_addr_lo_ld = 1'b1;
            w_state_nxt  = (r_kind == PK_RESP) ? ST_RX_DATA : ST_COMMIT;
          end
        end else if (w_expire) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_RX_DATA: begin
        if (bus.rx_valid) begin
          w_tile_shift = 1'b1;
          if (r_cnt == DATA_LAST) w_state_nxt = ST_COMMIT;
          else                    w_cnt_inc   = 1'b1;
        end else if (w_expire) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_kind         <= PK_RESP;
      r_cnt          <= '0;
      r_addr         <= '0;
      r_tile         <= '0;
      r_rd_data      <= '0;
      r_rd_data2     <= '0;
      r_rd_we        <= 1'b0;
      r_ps_data      <= '0;
      r_ps_we        <= 1'b0;
      r_err_bad_type <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_overflow <= 1'b0;
      r_bad_pend     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kind  <= w_kind_nxt;

      // Byte counter restarts on every state entry.
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (w_cnt_inc)         r_cnt <= r_cnt + 16'd1;

      if (w_addr_hi_ld) r_addr[15:8] <= bus.rx_data;
      if (w_addr_lo_ld) r_addr[7:0]  <= bus.rx_data;
      if (w_tile_shift) r_tile       <= {r_tile[TILE_BITS-9:0], bus.rx_data};

      r_rd_we <= w_rd_push;
      if (w_rd_push) begin
        r_rd_data  <= r_addr;
        r_rd_data2 <= r_tile;
      end
      r_ps_we <= w_ps_push;
      if (w_ps_push) r_ps_data <= r_addr;

      // A bad header on a commit cycle that overflows is reported one cycle
      // late so the error pulses never overlap.
      r_err_overflow <= w_ovf;
      r_err_timeout  <= w_tmo;
      r_err_bad_type <= (w_bad && !w_ovf) || r_bad_pend;
      r_bad_pend     <= w_bad && w_ovf;
    end
  end

  assign bus.dma_recv_read_queue_data  = r_rd_data;
  assign bus.dma_recv_read_queue_data2 = r_rd_data2;
  assign bus.dma_recv_read_queue_we    = r_rd_we;
  assign bus.prog_start_queue_data     = r_ps_data;
  assign bus.prog_start_queue_we       = r_ps_we;
  assign bus.err_bad_type              = r_err_bad_type;
  assign bus.err_timeout               = r_err_timeout;
  assign bus.err_overflow              = r_err_overflow;
endmodule

// File: tb/tb_dma_packet_receiver.sv
// Bench for dma_packet_receiver: a packet table plus hand-written timeout and
// reset sequences; every expected push/error is queued with the cycle it must
// appear in and matched by a negedge monitor.
module tb_dma_packet_receiver;
  import dma_pkt_pkg::*;

  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  dma_packet_receiver_if bus();

  dma_packet_receiver #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum int {EV_RD, EV_PS, EV_OVF, EV_BAD, EV_TMO} ev_e;

  typedef struct {
    ev_e          kind;
    int           cyc;
    logic [15:0]  addr;
    logic [287:0] tile;
  } exp_t;

  typedef struct {
    logic [7:0]  hdr;
    logic [15:0] addr;
    logic [7:0]  base;
    logic        rd_full;
    logic        ps_full;
    ev_e         exp;
    int          gap;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[11];

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected tile: payload byte i sits at [287-8i -: 8].
  function automatic logic [287:0] tile_of(input logic [7:0] base);
    logic [287:0] t;
    t = '0;
    for (int i = 0; i < 36; i++) t[287 - 8*i -: 8] = base + 8'(i);
    return t;
  endfunction

  function automatic exp_t mk(input ev_e k, input int c, input logic [15:0] a, input logic [287:0] t);
    exp_t e;
    e.kind = k; e.cyc = c; e.addr = a; e.tile = t;
    return e;
  endfunction

  task automatic observe(input ev_e k, input logic [15:0] a, input logic [287:0] t);
    exp_t e;
    check("event_expected", {287'b0, sb.size() != 0}, 288'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("event_kind", k, e.kind);
      check("event_cycle", cyc, e.cyc);
      if (k == EV_RD) begin
        check("rd_addr", a, e.addr);
        check("rd_tile", t, e.tile);
      end else if (k == EV_PS) begin
        check("ps_addr", a, e.addr);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.err_bad_type || bus.err_timeout || bus.err_overflow)
        check("err_exclusive",
              288'(int'(bus.err_bad_type) + int'(bus.err_timeout) + int'(bus.err_overflow)), 288'd1);
      if (bus.dma_recv_read_queue_we)
        observe(EV_RD, bus.dma_recv_read_queue_data, bus.dma_recv_read_queue_data2);
      if (bus.prog_start_queue_we) observe(EV_PS, bus.prog_start_queue_data, '0);
      if (bus.err_overflow)        observe(EV_OVF, '0, '0);
      if (bus.err_bad_type)        observe(EV_BAD, '0, '0);
      if (bus.err_timeout)         observe(EV_TMO, '0, '0);
    end
  end

  task automatic send_byte(input logic [7:0] b, output int bc);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    bc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic send_packet(input logic [7:0] hdr, input logic [15:0] addr,
                             input logic [7:0] base, input int ndata, output int last);
    send_byte(hdr, last);
    if (hdr == 8'd1 || hdr == 8'd2) begin
      send_byte(addr[15:8], last);
      send_byte(addr[7:0], last);
      for (int i = 0; i < ndata; i++) send_byte(base + 8'(i), last);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_we"},    bus.dma_recv_read_queue_we, 0);
    check({tag, "_ps_we"},    bus.prog_start_queue_we, 0);
    check({tag, "_errs"},     {bus.err_bad_type, bus.err_timeout, bus.err_overflow}, 0);
    check({tag, "_rd_data"},  bus.dma_recv_read_queue_data, 0);
    check({tag, "_rd_data2"}, bus.dma_recv_read_queue_data2, 0);
    check({tag, "_ps_data"},  bus.prog_start_queue_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int b;
    vec_t v;

    //            hdr    addr      base   rdF   psF   expect  gap
    vecs[0]  = '{8'h01, 16'h1234, 8'h00, 1'b0, 1'b0, EV_RD,  3};
    vecs[1]  = '{8'h02, 16'hABCD, 8'h00, 1'b0, 1'b0, EV_PS,  3};
    vecs[2]  = '{8'h07, 16'h0000, 8'h00, 1'b0, 1'b0, EV_BAD, 2};
    vecs[3]  = '{8'h02, 16'h0010, 8'h00, 1'b0, 1'b0, EV_PS,  3};
    vecs[4]  = '{8'h01, 16'hBEEF, 8'h40, 1'b1, 1'b0, EV_OVF, 0};
    vecs[5]  = '{8'h02, 16'h0001, 8'h00, 1'b1, 1'b0, EV_PS,  3};
    vecs[6]  = '{8'h02, 16'h5566, 8'h00, 1'b0, 1'b1, EV_OVF, 3};
    vecs[7]  = '{8'h01, 16'hCAFE, 8'h80, 1'b0, 1'b0, EV_RD,  0};
    vecs[8]  = '{8'h02, 16'h1357, 8'h00, 1'b0, 1'b0, EV_PS,  0};
    vecs[9]  = '{8'h01, 16'h0102, 8'hA0, 1'b0, 1'b0, EV_RD,  0};
    vecs[10] = '{8'h01, 16'hFFFF, 8'h10, 1'b0, 1'b0, EV_RD,  3};

    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.dma_recv_read_queue_full = 1'b0;
    bus.prog_start_queue_full    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("por");
    reset = 1'b0;
    idle(2);

    // Table: push/error lands 2 cycles after the last byte (1 for a bad header).
    foreach (vecs[i]) begin
      v = vecs[i];
      bus.dma_recv_read_queue_full = v.rd_full;
      bus.prog_start_queue_full    = v.ps_full;
      send_packet(v.hdr, v.addr, v.base, (v.hdr == 8'd1) ? 36 : 0, b);
      case (v.exp)
        EV_RD:   sb.push_back(mk(EV_RD, b + 2, v.addr, tile_of(v.base)));
        EV_PS:   sb.push_back(mk(EV_PS, b + 2, v.addr, '0));
        EV_OVF:  sb.push_back(mk(EV_OVF, b + 2, '0, '0));
        default: sb.push_back(mk(EV_BAD, b + 1, '0, '0));
      endcase
      idle(v.gap);
    end
    bus.dma_recv_read_queue_full = 1'b0;
    bus.prog_start_queue_full    = 1'b0;
    idle(4);

    // Timeout: idle count is 0 in the cycle after the byte, reaches TMO-1
    // TMO cycles after it, and the registered pulse follows one cycle later.
    send_byte(8'h01, b);
    send_byte(8'h12, b);
    sb.push_back(mk(EV_TMO, b + TMO + 1, '0, '0));
    idle(TMO + 5);
    send_packet(8'h02, 16'h5566, 8'h00, 0, b);
    sb.push_back(mk(EV_PS, b + 2, 16'h5566, '0));
    idle(3);

    // A byte arriving exactly on the expiry cycle keeps the packet alive.
    send_byte(8'h01, b);
    send_byte(8'h12, b);
    idle(TMO - 1);
    send_byte(8'h34, b);
    for (int i = 0; i < 36; i++) send_byte(8'h60 + 8'(i), b);
    sb.push_back(mk(EV_RD, b + 2, 16'h1234, tile_of(8'h60)));
    idle(4);

    // Reset in the middle of a tile.
    send_byte(8'h01, b);
    send_byte(8'hAA, b);
    send_byte(8'hBB, b);
    for (int i = 0; i < 20; i++) send_byte(8'hC0 + 8'(i), b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
    send_packet(8'h01, 16'h2468, 8'h30, 36, b);
    sb.push_back(mk(EV_RD, b + 2, 16'h2468, tile_of(8'h30)));
    idle(2);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    idle(TMO + 4);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
